// File: rtl/firroot_result_buf.sv
`timescale 1ns/1ps
// firroot_result_buf
// Re-aligns each FIR sample with the ROOT result that arrives ROOT_LAT
// cycles later, packs the pair as {fir, root}, and buffers it in a
// first-word-fall-through FIFO drained over valid/ready.
// Optional build macro FIRROOT_PEAK_EN adds Peak_o, the running unsigned
// maximum of accepted root results (cleared by Clr_ovf).
module firroot_result_buf #(
  parameter int DW       = 8,
  parameter int ROOT_LAT = 4,
  parameter int DEPTH    = 16,
  parameter int AW       = 4
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            In_valid,
  input  logic [DW-1:0]   Fir_i,
  input  logic [DW-1:0]   Root_i,
  output logic            Out_valid,
  input  logic            Out_ready,
  output logic [2*DW-1:0] Out_data,
  output logic [AW:0]     Level,
  output logic            Overflow,
  input  logic            Clr_ovf
`ifdef FIRROOT_PEAK_EN
  ,
  output logic [DW-1:0]   Peak_o
`endif
);

  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [ROOT_LAT-1:0] dl_v;
  logic [DW-1:0]       dl_f [ROOT_LAT];

  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [2*DW-1:0]     mem [DEPTH];

  logic                wr;
  logic [2*DW-1:0]     wr_word;
  logic                full;
  logic                empty;
  logic                rd;
  logic                wr_ok;
  logic                drop;

  // the last delay stage lines up with Root_i for the same sample
  assign wr      = dl_v[ROOT_LAT-1];
  assign wr_word = {dl_f[ROOT_LAT-1], Root_i};

  // extra pointer MSB separates full (MSBs differ) from empty (all equal)
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd    = Out_valid & Out_ready;
  // when full, a same-cycle read frees the head slot, which is exactly
  // the slot the write pointer addresses
  assign wr_ok = wr & (~full | rd);
  assign drop  = wr & full & ~rd;

  assign Out_valid = ~empty;
  assign Out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign Level     = wr_ptr - rd_ptr;

  // alignment delay line for {In_valid, Fir_i}; never stalls
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dl_v <= '0;
      for (int i = 0; i < ROOT_LAT; i++) dl_f[i] <= '0;
    end else begin
      dl_v[0] <= In_valid;
      dl_f[0] <= Fir_i;
      for (int i = 1; i < ROOT_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_f[i] <= dl_f[i-1];
      end
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset
  always_ff @(posedge Clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_word;
  end

  // read/write pointers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_INC;
      if (rd)    rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  // sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)       Overflow <= 1'b0;
    else if (drop)    Overflow <= 1'b1;
    else if (Clr_ovf) Overflow <= 1'b0;
  end

`ifdef FIRROOT_PEAK_EN
  // running max of accepted root results; a clear restarts from this write
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Peak_o <= '0;
    end else if (wr_ok) begin
      if (Clr_ovf || (Root_i > Peak_o)) Peak_o <= Root_i;
    end else if (Clr_ovf) begin
      Peak_o <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_firroot_result_buf.sv
`timescale 1ns/1ps
// Bench for firroot_result_buf: a ROOT emulator feeds Root_i late, and a
// queue-based reference model predicts FIFO contents, level and flags.
module tb_firroot_result_buf;

  localparam int DW    = 8;
  localparam int RL    = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          In_valid;
  logic [DW-1:0] Fir_i;
  logic [DW-1:0] Root_i;
  logic          Out_valid;
  logic          Out_ready;
  logic [15:0]   Out_data;
  logic [AW:0]   Level;
  logic          Overflow;
  logic          Clr_ovf;
`ifdef FIRROOT_PEAK_EN
  logic [DW-1:0] Peak_o;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] mq[$];
  logic [15:0] mexp[$];
  logic [15:0] got[$];
  bit          m_ovf;
  logic [7:0]  m_peak;
  bit          pv [64];
  logic [15:0] pw [64];
  logic [7:0]  rp [0:RL];
  int          cyc = 0;

  firroot_result_buf #(.DW(DW), .ROOT_LAT(RL), .DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid), .Fir_i(Fir_i),
    .Root_i(Root_i), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_data(Out_data), .Level(Level), .Overflow(Overflow),
    .Clr_ovf(Clr_ovf)
`ifdef FIRROOT_PEAK_EN
    , .Peak_o(Peak_o)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic model_reset();
    mq.delete();
    mexp.delete();
    got.delete();
    m_ovf  = 1'b0;
    m_peak = 8'h00;
    for (int i = 0; i < 64; i++) pv[i] = 1'b0;
  endtask

  // one clock: drive inputs, emulate ROOT, advance the model, sample after edge
  task automatic step(input logic v, input logic [7:0] f, input logic [7:0] r,
                      input logic rdy, input logic clr);
    bit          wv;
    logic [15:0] ww;
    bit          rd;
    bit          acc;
    In_valid  = v;
    Fir_i     = f;
    Out_ready = rdy;
    Clr_ovf   = clr;
    for (int i = RL; i > 0; i--) rp[i] = rp[i-1];
    rp[0]  = r;
    Root_i = rp[RL];
    pv[cyc % 64] = v;
    pw[cyc % 64] = {f, r};
    wv = 1'b0;
    ww = 16'h0;
    if (cyc >= RL) begin
      wv = pv[(cyc - RL) % 64];
      ww = pw[(cyc - RL) % 64];
    end
    #1;
    if (Out_valid && Out_ready) got.push_back(Out_data);
    rd  = (mq.size() > 0) && rdy;
    acc = wv && ((mq.size() < DEPTH) || rd);
    if (wv && !acc) m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    if (acc) begin
      if (clr || (ww[7:0] > m_peak)) m_peak = ww[7:0];
    end else if (clr) begin
      m_peak = 8'h00;
    end
    if (rd)  mexp.push_back(mq.pop_front());
    if (acc) mq.push_back(ww);
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && mq.size() > 0; k++)
      step(1'b0, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    for (int k = 0; k < RL + 1; k++)
      step(1'b0, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    logic [4:0] el;
    Rst_n = 1'b0; In_valid = 1'b0; Fir_i = '0; Root_i = '0;
    Out_ready = 1'b1; Clr_ovf = 1'b0;
    for (int i = 0; i <= RL; i++) rp[i] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      In_valid = ~In_valid;
      Fir_i    = 8'($urandom);
      Root_i   = 8'($urandom);
      @(posedge Clk); #1;
      checks++;
      if (Out_valid !== 1'b0 || Level !== 5'd0 || Overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: valid=%b level=%0d ovf=%b, want 0/0/0",
                 Out_valid, Level, Overflow);
      end
    end
    Rst_n = 1'b1;
    model_reset();
    step(1'b1, 8'h40, 8'h08, 1'b0, 1'b0);
    for (int k = 1; k <= RL; k++) begin
      checks++;
      if (Out_valid !== (mq.size() != 0) || Out_valid !== 1'b0) begin
        errors++;
        $display("FAIL first_latency: valid=%b early at cycle +%0d, want 0", Out_valid, k);
      end
      step(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    end
    el = 5'(mq.size());
    checks++;
    if (Out_valid !== 1'b1 || Out_data !== 16'h4008 || Level !== 5'd1 || Level !== el) begin
      errors++;
      $display("FAIL first_word: valid=%b data=%h level=%0d, want 1/4008/1",
               Out_valid, Out_data, Level);
    end
  endtask

  task automatic test_alignment();
    logic [15:0] e;
    drain();
    got.delete();
    mexp.delete();
    for (int i = 1; i <= 8; i++)
      step(1'b1, 8'(i), 8'(i + 8'h80), 1'b1, 1'b0);
    for (int k = 0; k < RL + 2; k++)
      step(1'b0, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL align_count: got %0d words, want 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      e = {8'(i + 1), 8'(i + 8'h81)};
      checks++;
      if (got[i] !== e) begin
        errors++;
        $display("FAIL align_word[%0d]: got %h, want %h", i, got[i], e);
      end
    end
  endtask

  task automatic test_back_pressure_full();
    logic [15:0] w0;
    logic [4:0]  el;
    drain();
    step(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    w0 = 16'h0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(8'hA0 + i), 8'($urandom), 1'b0, 1'b0);
      if (i == 0) w0 = pw[(cyc - 1) % 64];
    end
    for (int k = 0; k < RL; k++)
      step(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    el = 5'(mq.size());
    checks++;
    if (Level !== 5'd16 || Level !== el || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill16: level=%0d ovf=%b, want 16/0", Level, Overflow);
    end
    // 17th sample; its dropped write coincides with a clear, set must win
    step(1'b1, 8'hEE, 8'hEE, 1'b0, 1'b0);
    for (int k = 0; k < RL - 1; k++)
      step(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    step(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    checks++;
    if (Level !== 5'd16 || Overflow !== 1'b1 || Overflow !== m_ovf) begin
      errors++;
      $display("FAIL drop17: level=%0d ovf=%b, want 16/1", Level, Overflow);
    end
    checks++;
    if (Out_data !== w0 || Out_data !== mq[0]) begin
      errors++;
      $display("FAIL head_after_drop: data=%h, want %h", Out_data, w0);
    end
    step(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    checks++;
    if (Overflow !== 1'b0 || Level !== 5'd16) begin
      errors++;
      $display("FAIL clr_ovf: ovf=%b level=%0d, want 0/16", Overflow, Level);
    end
  endtask

  task automatic test_simul_full();
    got.delete();
    step(1'b1, 8'h5A, 8'hC3, 1'b0, 1'b0);
    for (int k = 0; k < RL - 1; k++)
      step(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    step(1'b0, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    checks++;
    if (Level !== 5'd16 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL simul_full: level=%0d ovf=%b, want 16/0", Level, Overflow);
    end
    for (int k = 0; k < DEPTH; k++)
      step(1'b0, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    checks++;
    if (got.size() != DEPTH + 1 || Level !== 5'd0) begin
      errors++;
      $display("FAIL simul_drain: reads=%0d level=%0d, want 17/0", got.size(), Level);
    end else begin
      checks++;
      if (got[DEPTH] !== 16'h5AC3) begin
        errors++;
        $display("FAIL simul_last: got %h, want 5ac3", got[DEPTH]);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    int         sent;
    logic       v;
    logic [4:0] el;
    drain();
    got.delete();
    mexp.delete();
    sent = 0;
    for (int k = 0; k < 400 && sent < 40; k++) begin
      v = 1'($urandom_range(0, 1));
      if (v) sent++;
      step(v, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      el = 5'(mq.size());
      checks++;
      if (Level !== el || Out_valid !== (mq.size() != 0)) begin
        errors++;
        $display("FAIL wrap_level: level=%0d valid=%b, want %0d/%b",
                 Level, Out_valid, el, (mq.size() != 0));
      end
    end
    drain();
    checks++;
    if (got.size() != mexp.size() || Overflow !== m_ovf || mq.size() != 0) begin
      errors++;
      $display("FAIL wrap_count: got %0d words ovf=%b, want %0d ovf=%b",
               got.size(), Overflow, mexp.size(), m_ovf);
    end
    for (int i = 0; i < got.size() && i < mexp.size(); i++) begin
      checks++;
      if (got[i] !== mexp[i]) begin
        errors++;
        $display("FAIL wrap_word[%0d]: got %h, want %h", i, got[i], mexp[i]);
      end
    end
    for (int k = 0; k < 10; k++)
      step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    el = 5'(mq.size());
    checks++;
    if (Level !== el || el == 5'd0) begin
      errors++;
      $display("FAIL pre_reset_level: level=%0d, want %0d", Level, el);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (Out_valid !== 1'b0 || Level !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b level=%0d, want 0/0", Out_valid, Level);
    end
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < RL + 2; k++) begin
      step(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
      checks++;
      if (Level !== 5'd0 || Out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_flush: level=%0d valid=%b, want 0/0", Level, Out_valid);
      end
    end
  endtask

`ifdef FIRROOT_PEAK_EN
  task automatic test_peak();
    drain();
    step(1'b0, 8'($urandom), 8'($urandom), 1'b1, 1'b1);
    step(1'b1, 8'h01, 8'h10, 1'b1, 1'b0);
    step(1'b1, 8'h02, 8'hF0, 1'b1, 1'b0);
    step(1'b1, 8'h03, 8'h20, 1'b1, 1'b0);
    for (int k = 0; k < RL + 1; k++)
      step(1'b0, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    checks++;
    if (Peak_o !== 8'hF0 || Peak_o !== m_peak) begin
      errors++;
      $display("FAIL peak_max: got %h, want f0", Peak_o);
    end
    step(1'b1, 8'h77, 8'h05, 1'b1, 1'b0);
    for (int k = 0; k < RL - 1; k++)
      step(1'b0, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    step(1'b0, 8'($urandom), 8'($urandom), 1'b1, 1'b1);
    checks++;
    if (Peak_o !== 8'h05 || Peak_o !== m_peak) begin
      errors++;
      $display("FAIL peak_clr_write: got %h, want 05", Peak_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alignment();
    test_back_pressure_full();
    test_simul_full();
    test_wrap_and_reset();
`ifdef FIRROOT_PEAK_EN
    test_peak();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
